// File: rtl/hazard3_regfile_pkg.sv
// hazard3_regfile_pkg: shared FSM encoding and write-forward priority for the register file
package hazard3_regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic [1:0] fwd_sel(input logic [1:0] hit);
    return hit[1] ? 2'b10 : {1'b0, hit[0]};
  endfunction

endpackage

// File: rtl/hazard3_regfile_bypass.sv
// hazard3_regfile_bypass: per-read-port forward mux from same-cycle writes
module hazard3_regfile_bypass
  import hazard3_regfile_pkg::*;
#(
  parameter int W_ADDR   = 5,
  parameter int W_DATA   = 32,
  parameter int N_WPORTS = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_X0  = 1
) (
  input  logic [W_ADDR-1:0]          raddr,
  input  logic [W_DATA-1:0]          mem_data,
  input  logic [N_WPORTS*W_ADDR-1:0] waddr,
  input  logic [N_WPORTS*W_DATA-1:0] wdata,
  input  logic [N_WPORTS-1:0]        wen,
  output logic [W_DATA-1:0]          rdata
);
  logic [1:0]             hit;
  logic [1:0]             sel;
  logic [1:0][W_DATA-1:0] wd;
  for (genvar j = 0; j < 2; j++) begin : g_w
    if (j < N_WPORTS) begin : g_on
      assign hit[j] = BYPASS != 0 && wen[j] && waddr[j*W_ADDR +: W_ADDR] == raddr;
      assign wd[j]  = wdata[j*W_DATA +: W_DATA];
    end else begin : g_off
      assign hit[j] = 1'b0;
      assign wd[j]  = '0;
    end
  end
  assign sel   = fwd_sel(hit);
  assign rdata = (ZERO_X0 != 0 && raddr == '0) ? '0 : sel[1] ? wd[1] : sel[0] ? wd[0] : mem_data;
endmodule

// File: rtl/hazard3_regfile_mwnr.sv
// hazard3_regfile_mwnr: multi-port register file with write forwarding and post-reset clear sequence
module hazard3_regfile_mwnr
  import hazard3_regfile_pkg::*;
#(
  parameter int N_REGS         = 32,
  parameter int W_DATA         = 32,
  parameter int N_RPORTS       = 2,
  parameter int N_WPORTS       = 1,
  parameter int BYPASS         = 1,
  parameter int ZERO_X0        = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int INIT_REG       = 10,
  parameter logic [W_DATA-1:0] INIT_VAL = '0,
  localparam int W_ADDR        = $clog2(N_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_RPORTS*W_ADDR-1:0] raddr,
  input  logic [N_RPORTS-1:0]        ren,
  output logic [N_RPORTS*W_DATA-1:0] rdata,
  input  logic [N_WPORTS*W_ADDR-1:0] waddr,
  input  logic [N_WPORTS*W_DATA-1:0] wdata,
  input  logic [N_WPORTS-1:0]        wen,
  output logic                       clear_busy
);
  logic [W_DATA-1:0]               mem [N_REGS];
  state_t                          state;
  logic [W_ADDR-1:0]               cnt;
  logic                            init_ph;
  logic [N_WPORTS-1:0]             wen_eff;
  logic [N_RPORTS-1:0][W_DATA-1:0] fwd;

  for (genvar j = 0; j < N_WPORTS; j++) begin : g_wen
    assign wen_eff[j] = wen[j] && !(ZERO_X0 != 0 && waddr[j*W_ADDR +: W_ADDR] == '0);
  end

  for (genvar k = 0; k < N_RPORTS; k++) begin : g_rd
    hazard3_regfile_bypass #(
      .W_ADDR(W_ADDR), .W_DATA(W_DATA), .N_WPORTS(N_WPORTS), .BYPASS(BYPASS), .ZERO_X0(ZERO_X0)
    ) u_byp (
      .raddr(raddr[k*W_ADDR +: W_ADDR]),
      .mem_data(mem[raddr[k*W_ADDR +: W_ADDR]]),
      .waddr(waddr),
      .wdata(wdata),
      .wen(wen_eff),
      .rdata(fwd[k])
    );
  end

  // init_ph marks the extra cycle after the zero-fill that loads INIT_VAL
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_RUN;
      clear_busy <= CLEAR_ON_RESET != 0;
      cnt        <= '0;
      init_ph    <= 1'b0;
    end else if (state == ST_CLEAR) begin
      cnt     <= init_ph ? cnt : cnt + 1'b1;
      init_ph <= init_ph | (cnt == W_ADDR'(N_REGS - 1));
      if (init_ph) begin
        state      <= ST_RUN;
        clear_busy <= 1'b0;
      end
    end

  always_ff @(posedge clk)
    if (state == ST_CLEAR)
      mem[init_ph ? W_ADDR'(INIT_REG) : cnt] <= init_ph ? INIT_VAL : '0;
    else
      for (int j = 0; j < N_WPORTS; j++)
        if (wen_eff[j]) mem[waddr[j*W_ADDR +: W_ADDR]] <= wdata[j*W_DATA +: W_DATA];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      rdata <= '0;
    else
      for (int k = 0; k < N_RPORTS; k++)
        if (ren[k]) rdata[k*W_DATA +: W_DATA] <= state == ST_CLEAR ? '0 : fwd[k];
endmodule

// File: tb/tb_hazard3_regfile_mwnr.sv
// tb_hazard3_regfile_mwnr: randomized self-checking bench against an array-based reference model
module tb_hazard3_regfile_mwnr;
  localparam logic [31:0] IV = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  raddr = '0;
  logic [1:0]  ren = '0;
  logic [63:0] rdata;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  wen = '0;
  logic        clear_busy;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [32];
  logic [31:0] exp_rd [2];

  hazard3_regfile_mwnr #(.N_WPORTS(2), .INIT_VAL(IV)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .ren(ren), .rdata(rdata),
    .waddr(waddr), .wdata(wdata), .wen(wen), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  task automatic init_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[10] = IV;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
  endtask

  // one RUN-mode cycle: drive, predict with the model, advance past the edge
  task automatic cyc(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                     input logic [31:0] wd0, input logic [31:0] wd1);
    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    ra[0] = ra0; ra[1] = ra1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
    ren = re; raddr = {ra1, ra0}; wen = we; waddr = {wa1, wa0}; wdata = {wd1, wd0};
    for (int k = 0; k < 2; k++)
      if (re[k]) begin
        exp_rd[k] = model[ra[k]];
        for (int j = 0; j < 2; j++) if (we[j] && wa[j] == ra[k]) exp_rd[k] = wd[j];
        if (ra[k] == 5'd0) exp_rd[k] = 32'h0;
      end
    for (int j = 0; j < 2; j++) if (we[j] && wa[j] != 5'd0) model[wa[j]] = wd[j];
    @(posedge clk); #1;
    ren = '0; wen = '0;
  endtask

  task automatic run_clear(input logic [4:0] wreg, output int busy);
    busy = 0;
    for (int i = 0; i < 100 && clear_busy; i++) begin
      busy++;
      ren = 2'b11; raddr = {5'd10, wreg};
      wen = 2'b11; waddr = {wreg, wreg}; wdata = {32'h1357_9BDF, 32'h5555_AAAA};
      @(posedge clk); #1;
      tests++;
      if (rdata !== 64'h0) begin fails++; $display("FAIL clear_rdata: got %h expected 0", rdata); end
    end
    ren = '0; wen = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ren = '0; wen = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    tests++;
    if (clear_busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", clear_busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_clear();
    int busy;
    run_clear(5'd4, busy);
    tests++;
    if (busy != 33) begin fails++; $display("FAIL clear_len: got %0d expected 33", busy); end
    init_model();
  endtask

  task automatic test_init_values();
    cyc(2'b11, 5'd10, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tests++;
    if (rdata[31:0] !== IV) begin fails++; $display("FAIL init_reg10: got %h expected %h", rdata[31:0], IV); end
    tests++;
    if (rdata[63:32] !== 32'h0) begin fails++; $display("FAIL init_reg5: got %h expected 0", rdata[63:32]); end
    cyc(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tests++;
    if (rdata[31:0] !== 32'h0) begin fails++; $display("FAIL clear_wen_ignored: got %h expected 0", rdata[31:0]); end
  endtask

  task automatic test_bypass();
    cyc(2'b10, 5'd0, 5'd3, 2'b01, 5'd3, 5'd0, 32'hDEAD_BEEF, 32'h0);
    tests++;
    if (rdata[63:32] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bypass: got %h expected deadbeef", rdata[63:32]); end
    cyc(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tests++;
    if (rdata[31:0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bypass_commit: got %h expected deadbeef", rdata[31:0]); end
  endtask

  task automatic test_wport_priority();
    cyc(2'b01, 5'd7, 5'd0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22);
    tests++;
    if (rdata[31:0] !== 32'h22) begin fails++; $display("FAIL prio_bypass: got %h expected 22", rdata[31:0]); end
    cyc(2'b10, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tests++;
    if (rdata[63:32] !== 32'h22) begin fails++; $display("FAIL prio_commit: got %h expected 22", rdata[63:32]); end
  endtask

  task automatic test_x0();
    cyc(2'b11, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tests++;
    if (rdata !== 64'h0) begin fails++; $display("FAIL x0_bypass: got %h expected 0", rdata); end
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      tests++;
      if (rdata !== 64'h0) begin fails++; $display("FAIL x0_read: got %h expected 0", rdata); end
    end
  endtask

  task automatic test_hold();
    cyc(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 5'($urandom_range(1, 31)), 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      tests++;
      if (rdata[31:0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hold: got %h expected deadbeef", rdata[31:0]); end
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    return $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(2'($urandom), rnd_addr(), rnd_addr(), 2'($urandom), rnd_addr(), rnd_addr(), $urandom, $urandom);
      tests++;
      if (rdata !== {exp_rd[1], exp_rd[0]}) begin
        fails++; $display("FAIL random[%0d]: got %h expected %h", i, rdata, {exp_rd[1], exp_rd[0]});
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    tests++;
    if (clear_busy !== 1'b1) begin fails++; $display("FAIL midclear_busy: got %b expected 1", clear_busy); end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (rdata !== 64'h0 || clear_busy !== 1'b1) begin
      fails++; $display("FAIL midclear_reset: got rdata=%h busy=%b expected 0/1", rdata, clear_busy);
    end
    rst_n = 1'b1;
    run_clear(5'd20, busy);
    tests++;
    if (busy != 33) begin fails++; $display("FAIL restart_len: got %0d expected 33", busy); end
    init_model();
    cyc(2'b11, 5'd20, 5'd10, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tests++;
    if (rdata !== {IV, 32'h0}) begin fails++; $display("FAIL restart_vals: got %h expected %h", rdata, {IV, 32'h0}); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_init_values();
    test_bypass();
    test_wport_priority();
    test_x0();
    test_hold();
    test_random(400);
    test_reset_mid_clear();
    test_random(200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard3_regfile_mwnr.md
HAZARD3_REGFILE_MWNR -- requirements
Module: hazard3_regfile_mwnr

Interface
REQ-001 SHALL have parameter N_REGS, default 32: number of registers, power of two, 2..64.
REQ-002 SHALL have parameter W_DATA, default 32: register width in bits.
REQ-003 SHALL have parameter N_RPORTS, default 2: read port count, 1..4.
REQ-004 SHALL have parameter N_WPORTS, default 1: write port count, 1..2.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have parameter ZERO_X0, default 1: 1 = register 0 hardwired to zero.
REQ-007 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = sequential zero-fill of storage after reset.
REQ-008 SHALL have parameters INIT_REG (default 10) and INIT_VAL (default 0): register loaded with INIT_VAL at the end of the clear sequence.
REQ-009 SHALL define localparam W_ADDR = $clog2(N_REGS).
REQ-010 SHALL have ports: clk, input, 1, clock; rst_n, input, 1, reset.
REQ-011 SHALL have ports: raddr, input, N_RPORTS*W_ADDR, read addresses with port k at bits [k*W_ADDR +: W_ADDR]; ren, input, N_RPORTS, per-port read enable.
REQ-012 SHALL have port rdata, output, N_RPORTS*W_DATA, registered read data, packed like raddr.
REQ-013 SHALL have ports waddr, input, N_WPORTS*W_ADDR; wdata, input, N_WPORTS*W_DATA; wen, input, N_WPORTS: per-port write address, data and enable.
REQ-014 SHALL have port clear_busy, output, 1: high while the clear sequence runs.
REQ-015 One clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-016 Read latency SHALL be exactly 1 cycle: rdata[k] after edge N reflects raddr[k] sampled at edge N when ren[k]=1.
REQ-017 When ren[k]=0, rdata[k] SHALL hold its previous value.
REQ-018 Writes SHALL commit at the clock edge at which wen[j]=1.
REQ-019 If two write ports target the same address in one cycle, the higher-index port SHALL win.
REQ-020 BYPASS=1: a read and a write to the same address in one cycle SHALL return the new wdata, with the winning port per REQ-019; BYPASS=0: old contents are returned.
REQ-021 ZERO_X0=1: writes to address 0 SHALL be dropped and reads of address 0 SHALL return 0, including under bypass.
REQ-022 Writes to addresses >= N_REGS SHALL be impossible by construction, since N_REGS is a power of two.
REQ-023 FSM SHALL have states CLEAR and RUN; CLEAR_ON_RESET=1: reset enters CLEAR, otherwise reset enters RUN.
REQ-024 In CLEAR, a W_ADDR counter SHALL start at 0 and write zero to one register per cycle, incrementing each cycle.
REQ-025 After the counter reaches N_REGS-1, the FSM SHALL write INIT_VAL to INIT_REG in one further cycle and then enter RUN, so clear_busy is high for N_REGS+1 cycles.
REQ-026 In CLEAR, wen SHALL be ignored, ren SHALL be honoured, and rdata SHALL be forced to 0.
REQ-027 Reset asserted mid-CLEAR SHALL restart the sequence from address 0.

Reset
REQ-028 On rst_n low: rdata SHALL be 0, the FSM SHALL be in CLEAR (or RUN per REQ-023), the counter SHALL be 0, and clear_busy SHALL be 1 if CLEAR_ON_RESET else 0.
REQ-029 The storage array SHALL NOT be asynchronously reset; it SHALL stay BRAM/LUTRAM-inferable.

Structure
REQ-030 FSM state encodings and the bypass-priority function SHALL live in the shared package hazard3_regfile_pkg.
REQ-031 One sub-module SHALL exist: hazard3_regfile_bypass, a combinational per-read-port forward mux instantiated N_RPORTS times.
REQ-032 The storage array SHALL have a single write process; N_WPORTS=2 SHALL use a flop array, while N_WPORTS=1 SHALL stay RAM-inferable.

Verification
REQ-033 Reset release, N_REGS=32 -> clear_busy high for exactly 33 cycles; then reading reg 10 returns INIT_VAL and reading reg 5 returns 0.
REQ-034 Write 0xDEADBEEF to reg 3 via port 0 while port 1 reads reg 3 in the same cycle -> rdata1 = 0xDEADBEEF next cycle with BYPASS=1, 0 with BYPASS=0.
REQ-035 N_WPORTS=2 writes reg 7 with 0x11 on port 0 and 0x22 on port 1 in the same cycle -> a subsequent read of reg 7 returns 0x22.
REQ-036 Write 0xFFFFFFFF to reg 0 with a concurrent read of reg 0 -> rdata = 0 in that cycle and in all later cycles.
REQ-037 Assert rst_n low at clear counter = 12, hold 2 cycles, then release -> clear restarts from 0 and clear_busy stays high a full 33 cycles; wen pulses during CLEAR leave the target register at 0.
REQ-038 ren[0]=0 for 3 cycles while raddr[0] changes -> rdata0 holds its last value.
